// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet transmit header generator: field widths,
// FSM state encoding and tkeep/byte-count conversion helpers.
package eth_pkg;

  localparam int unsigned ETH_HDR_BYTES = 14;
  localparam int unsigned ETH_MAC_W     = 48;
  localparam int unsigned ETH_LEN_W     = 16;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    TAIL
  } tx_state_t;

  // Byte enables are contiguous from the LSB; any other pattern maps to 0.
  function automatic logic [3:0] keep2cnt(input logic [7:0] keep);
    logic [3:0] cnt;
    case (keep)
      8'h01:   cnt = 4'd1;
      8'h03:   cnt = 4'd2;
      8'h07:   cnt = 4'd3;
      8'h0F:   cnt = 4'd4;
      8'h1F:   cnt = 4'd5;
      8'h3F:   cnt = 4'd6;
      8'h7F:   cnt = 4'd7;
      8'hFF:   cnt = 4'd8;
      default: cnt = 4'd0;
    endcase
    return cnt;
  endfunction

  function automatic logic [7:0] cnt2keep(input logic [3:0] cnt);
    logic [7:0] keep;
    case (cnt)
      4'd0:    keep = 8'h00;
      4'd1:    keep = 8'h01;
      4'd2:    keep = 8'h03;
      4'd3:    keep = 8'h07;
      4'd4:    keep = 8'h0F;
      4'd5:    keep = 8'h1F;
      4'd6:    keep = 8'h3F;
      4'd7:    keep = 8'h7F;
      default: keep = 8'hFF;
    endcase
    return keep;
  endfunction

endpackage

// File: rtl/eth_tx_gen.sv
// Prepends a 14-byte Ethernet header (dst, src, length) to a payload stream,
// shifting the payload by 2 bytes so header and payload pack on the 64-bit bus.
module eth_tx_gen
  import eth_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [47:0] local_addr,
  input  logic [47:0] remote_addr,
  input  logic [15:0] tx_size,
  input  logic [63:0] tx_orin_tdata,
  input  logic [7:0]  tx_orin_tkeep,
  input  logic        tx_orin_tvalid,
  input  logic        tx_orin_tlast,
  input  logic        tx_orin_tuser,
  output logic        tx_orin_tready,
  output logic [63:0] tx_frame_tdata,
  output logic [7:0]  tx_frame_tkeep,
  output logic        tx_frame_tvalid,
  output logic        tx_frame_tlast,
  output logic        tx_frame_tuser,
  input  logic        tx_frame_tready,
  output logic [31:0] tx_frame_cnt
);

  if (AXIS_DATA_WIDTH != 64) begin : g_width_check
    $error("eth_tx_gen: AXIS_DATA_WIDTH must be 64");
  end

  tx_state_t              state, state_n;
  logic [ETH_MAC_W-1:0]   src_q, dst_q;
  logic [ETH_LEN_W-1:0]   len_q;
  logic [47:0]            hold_data;
  logic [3:0]             hold_cnt;
  logic                   err_q;
  logic [31:0]            frame_cnt_q;

  logic [3:0]             in_cnt;
  logic                   in_hs;
  logic                   payload_hs;
  logic                   last_hs;

  assign in_cnt     = keep2cnt(tx_orin_tkeep);
  assign in_hs      = tx_orin_tvalid & tx_frame_tready;
  assign payload_hs = ((state == HDR1) || (state == DATA)) && in_hs;
  assign last_hs    = tx_frame_tvalid & tx_frame_tready & tx_frame_tlast;

  assign tx_frame_cnt = frame_cnt_q;

  always_comb begin
    state_n         = state;
    tx_frame_tdata  = '0;
    tx_frame_tkeep  = '0;
    tx_frame_tvalid = 1'b0;
    tx_frame_tlast  = 1'b0;
    tx_frame_tuser  = 1'b0;
    tx_orin_tready  = 1'b0;

    case (state)
      IDLE: begin
        if (tx_orin_tvalid) state_n = HDR0;
      end

      HDR0: begin
        tx_frame_tdata  = {src_q[15:0], dst_q};
        tx_frame_tkeep  = '1;
        tx_frame_tvalid = 1'b1;
        if (tx_frame_tready) state_n = HDR1;
      end

      HDR1, DATA: begin
        // Low 2 payload bytes complete the current word; the upper 6 wait in hold_data.
        if (state == HDR1) tx_frame_tdata = {tx_orin_tdata[15:0], len_q, src_q[47:16]};
        else               tx_frame_tdata = {tx_orin_tdata[15:0], hold_data};
        tx_frame_tkeep  = '1;
        tx_frame_tvalid = tx_orin_tvalid;
        tx_orin_tready  = tx_frame_tready;
        if (tx_orin_tlast && (in_cnt <= 4'd2)) begin
          tx_frame_tkeep = cnt2keep(in_cnt + 4'd6);
          tx_frame_tlast = 1'b1;
          tx_frame_tuser = err_q | tx_orin_tuser;
        end
        if (in_hs) begin
          if (!tx_orin_tlast)         state_n = DATA;
          else if (in_cnt <= 4'd2)    state_n = IDLE;
          else                        state_n = TAIL;
        end
      end

      TAIL: begin
        tx_frame_tdata  = {16'h0000, hold_data};
        tx_frame_tkeep  = cnt2keep(hold_cnt - 4'd2);
        tx_frame_tvalid = 1'b1;
        tx_frame_tlast  = 1'b1;
        tx_frame_tuser  = err_q;
        if (tx_frame_tready) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      hold_data   <= '0;
      hold_cnt    <= '0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state <= state_n;
      if ((state == IDLE) && tx_orin_tvalid) begin
        src_q <= local_addr;
        dst_q <= remote_addr;
        len_q <= tx_size;
      end
      if (payload_hs) begin
        hold_data <= tx_orin_tdata[63:16];
        hold_cnt  <= in_cnt;
        err_q     <= err_q | tx_orin_tuser;
      end
      // Completion overrides the accumulate above so the next frame starts clean.
      if (last_hs) begin
        frame_cnt_q <= frame_cnt_q + 32'd1;
        err_q       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_gen.sv
// Directed self-checking bench for eth_tx_gen: header layout, realignment,
// tail handling, backpressure, error flag, parameter snapshot and reset.
module tb_eth_tx_gen;

  logic        clk;
  logic        rstn;
  logic [47:0] local_addr;
  logic [47:0] remote_addr;
  logic [15:0] tx_size;
  logic [63:0] tx_orin_tdata;
  logic [7:0]  tx_orin_tkeep;
  logic        tx_orin_tvalid;
  logic        tx_orin_tlast;
  logic        tx_orin_tuser;
  logic        tx_orin_tready;
  logic [63:0] tx_frame_tdata;
  logic [7:0]  tx_frame_tkeep;
  logic        tx_frame_tvalid;
  logic        tx_frame_tlast;
  logic        tx_frame_tuser;
  logic        tx_frame_tready;
  logic [31:0] tx_frame_cnt;

  int errors = 0;
  int checks = 0;

  eth_tx_gen #(.AXIS_DATA_WIDTH(64)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .local_addr      (local_addr),
    .remote_addr     (remote_addr),
    .tx_size         (tx_size),
    .tx_orin_tdata   (tx_orin_tdata),
    .tx_orin_tkeep   (tx_orin_tkeep),
    .tx_orin_tvalid  (tx_orin_tvalid),
    .tx_orin_tlast   (tx_orin_tlast),
    .tx_orin_tuser   (tx_orin_tuser),
    .tx_orin_tready  (tx_orin_tready),
    .tx_frame_tdata  (tx_frame_tdata),
    .tx_frame_tkeep  (tx_frame_tkeep),
    .tx_frame_tvalid (tx_frame_tvalid),
    .tx_frame_tlast  (tx_frame_tlast),
    .tx_frame_tuser  (tx_frame_tuser),
    .tx_frame_tready (tx_frame_tready),
    .tx_frame_cnt    (tx_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle_no = 0;
  always @(posedge clk) cycle_no <= cycle_no + 1;

  // Payload stimulus table
  logic [63:0] pl_data [8];
  logic [7:0]  pl_keep [8];
  logic        pl_user [8];

  // Captured output beats
  logic [63:0] out_data [16];
  logic [7:0]  out_keep [16];
  logic        out_last [16];
  logic        out_user [16];
  int          out_cyc  [16];
  int          n_out;
  int          stall_viol;
  int          rdy_viol;
  logic        timed_out;

  // Drives n beats of payload and records accepted frame beats until tlast.
  // rdy_mode 0: sink always ready; 1: ready toggles 1010...
  // chg_size: switch tx_size to 16'h0020 one cycle after the frame starts.
  task automatic run_frame(input int n_beats, input int rdy_mode, input bit chg_size);
    int   pi;
    bit   done;
    bit   consume;
    logic prev_stall;
    logic [63:0] prev_data;
    logic [7:0]  prev_keep;
    logic        prev_last;
    pi = 0; done = 0; n_out = 0; stall_viol = 0; rdy_viol = 0; prev_stall = 0;
    prev_data = '0; prev_keep = '0; prev_last = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (chg_size && cyc == 1) tx_size = 16'h0020;
      tx_orin_tvalid = (pi < n_beats);
      tx_orin_tdata  = (pi < n_beats) ? pl_data[pi] : 64'h0;
      tx_orin_tkeep  = (pi < n_beats) ? pl_keep[pi] : 8'h00;
      tx_orin_tuser  = (pi < n_beats) ? pl_user[pi] : 1'b0;
      tx_orin_tlast  = (pi == n_beats - 1);
      tx_frame_tready = (rdy_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      @(negedge clk);
      if (prev_stall && (tx_frame_tdata !== prev_data || tx_frame_tkeep !== prev_keep ||
                         tx_frame_tlast !== prev_last))
        stall_viol++;
      if (!tx_frame_tready && tx_orin_tready) rdy_viol++;
      prev_stall = tx_frame_tvalid && !tx_frame_tready;
      prev_data  = tx_frame_tdata;
      prev_keep  = tx_frame_tkeep;
      prev_last  = tx_frame_tlast;
      if (tx_frame_tvalid && tx_frame_tready && n_out < 16) begin
        out_data[n_out] = tx_frame_tdata;
        out_keep[n_out] = tx_frame_tkeep;
        out_last[n_out] = tx_frame_tlast;
        out_user[n_out] = tx_frame_tuser;
        out_cyc[n_out]  = cycle_no;
        n_out++;
        if (tx_frame_tlast) done = 1;
      end
      consume = tx_orin_tvalid && tx_orin_tready;
      @(posedge clk); #1;
      if (consume) pi++;
    end
    tx_orin_tvalid = 0;
    tx_orin_tlast  = 0;
    tx_orin_tuser  = 0;
    tx_frame_tready = 1;
    timed_out = !done;
  endtask

  task automatic load_two_beat();
    pl_data[0] = 64'h8877665544332211; pl_keep[0] = 8'hFF; pl_user[0] = 0;
    pl_data[1] = 64'hFFEEDDCCBBAA9988; pl_keep[1] = 8'hFF; pl_user[1] = 0;
  endtask

  task automatic load_min();
    pl_data[0] = 64'h00000000000000AB; pl_keep[0] = 8'h01; pl_user[0] = 0;
  endtask

  task automatic test_reset();
    rstn = 0;
    tx_orin_tvalid = 0; tx_orin_tlast = 0; tx_orin_tuser = 0;
    tx_orin_tdata = '0; tx_orin_tkeep = '0; tx_frame_tready = 1;
    local_addr = 48'h0A0B0C0D0E0F; remote_addr = 48'h112233445566; tx_size = 16'h0010;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1;
    @(negedge clk);
    checks++;
    if ({tx_frame_tvalid, tx_frame_tlast, tx_frame_tuser, tx_orin_tready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000",
               {tx_frame_tvalid, tx_frame_tlast, tx_frame_tuser, tx_orin_tready});
    end
    checks++;
    if (tx_frame_tdata !== 64'h0 || tx_frame_tkeep !== 8'h0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h required 0/0", tx_frame_tdata, tx_frame_tkeep);
    end
    checks++;
    if (tx_frame_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d required 0", tx_frame_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [63:0] exp_d [4];
    logic [7:0]  exp_k [4];
    exp_d[0] = 64'h0E0F112233445566; exp_k[0] = 8'hFF;
    exp_d[1] = 64'h221100100A0B0C0D; exp_k[1] = 8'hFF;
    exp_d[2] = 64'h9988887766554433; exp_k[2] = 8'hFF;
    exp_d[3] = 64'h0000FFEEDDCCBBAA; exp_k[3] = 8'h3F;
    load_two_beat();
    run_frame(2, 0, 0);
    checks++;
    if (timed_out || n_out !== 4) begin
      errors++;
      $display("FAIL basic_beats: got %0d beats (timeout=%0b) required 4", n_out, timed_out);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_data[i] !== exp_d[i] || out_keep[i] !== exp_k[i] || out_last[i] !== (i == 3)) begin
        errors++;
        $display("FAIL basic_beat%0d: got %h/%h/%b required %h/%h/%b", i,
                 out_data[i], out_keep[i], out_last[i], exp_d[i], exp_k[i], (i == 3));
      end
    end
    checks++;
    if (tx_frame_cnt !== 32'd1) begin
      errors++;
      $display("FAIL basic_cnt: got %0d required 1", tx_frame_cnt);
    end
  endtask

  task automatic test_min_frame();
    load_min();
    run_frame(1, 0, 0);
    checks++;
    if (timed_out || n_out !== 2) begin
      errors++;
      $display("FAIL min_beats: got %0d beats required 2", n_out);
    end
    checks++;
    if (out_data[1] !== 64'h00AB00100A0B0C0D || out_keep[1] !== 8'h7F ||
        out_last[1] !== 1'b1 || out_user[1] !== 1'b0) begin
      errors++;
      $display("FAIL min_last: got %h/%h/%b/%b required 00ab00100a0b0c0d/7f/1/0",
               out_data[1], out_keep[1], out_last[1], out_user[1]);
    end
    checks++;
    if (tx_frame_cnt !== 32'd2) begin
      errors++;
      $display("FAIL min_cnt: got %0d required 2", tx_frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_d [4];
    exp_d[0] = 64'h0E0F112233445566;
    exp_d[1] = 64'h221100100A0B0C0D;
    exp_d[2] = 64'h9988887766554433;
    exp_d[3] = 64'h0000FFEEDDCCBBAA;
    load_two_beat();
    run_frame(2, 1, 0);
    checks++;
    if (timed_out || n_out !== 4) begin
      errors++;
      $display("FAIL bp_beats: got %0d beats required 4", n_out);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_data[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL bp_beat%0d: got %h required %h", i, out_data[i], exp_d[i]);
      end
    end
    checks++;
    if (out_keep[3] !== 8'h3F || out_last[3] !== 1'b1) begin
      errors++;
      $display("FAIL bp_tail: got %h/%b required 3f/1", out_keep[3], out_last[3]);
    end
    checks++;
    if (stall_viol !== 0 || rdy_viol !== 0) begin
      errors++;
      $display("FAIL bp_stable: got stall=%0d ready=%0d violations required 0/0",
               stall_viol, rdy_viol);
    end
    checks++;
    if (tx_frame_cnt !== 32'd3) begin
      errors++;
      $display("FAIL bp_cnt: got %0d required 3", tx_frame_cnt);
    end
  endtask

  task automatic test_error();
    logic [63:0] exp_d [5];
    logic [7:0]  exp_k [5];
    exp_d[2] = 64'h0908070605040302; exp_k[2] = 8'hFF;
    exp_d[3] = 64'h11100F0E0D0C0B0A; exp_k[3] = 8'hFF;
    exp_d[4] = 64'h0000000000001312; exp_k[4] = 8'h03;
    pl_data[0] = 64'h0706050403020100; pl_keep[0] = 8'hFF; pl_user[0] = 1;
    pl_data[1] = 64'h0F0E0D0C0B0A0908; pl_keep[1] = 8'hFF; pl_user[1] = 0;
    pl_data[2] = 64'h0000000013121110; pl_keep[2] = 8'h0F; pl_user[2] = 0;
    run_frame(3, 0, 0);
    checks++;
    if (timed_out || n_out !== 5) begin
      errors++;
      $display("FAIL err_beats: got %0d beats required 5", n_out);
    end
    for (int i = 2; i < 5; i++) begin
      checks++;
      if (out_data[i] !== exp_d[i] || out_keep[i] !== exp_k[i]) begin
        errors++;
        $display("FAIL err_beat%0d: got %h/%h required %h/%h", i,
                 out_data[i], out_keep[i], exp_d[i], exp_k[i]);
      end
    end
    checks++;
    if ({out_user[0], out_user[1], out_user[2], out_user[3], out_user[4]} !== 5'b00001) begin
      errors++;
      $display("FAIL err_tuser: got %b required 00001",
               {out_user[0], out_user[1], out_user[2], out_user[3], out_user[4]});
    end
    load_min();
    run_frame(1, 0, 0);
    checks++;
    if (n_out !== 2 || out_user[1] !== 1'b0 || out_last[1] !== 1'b1) begin
      errors++;
      $display("FAIL err_next_clean: got beats=%0d tuser=%b required 2/0", n_out, out_user[1]);
    end
  endtask

  task automatic test_back_to_back();
    int a_last_cyc;
    load_min();
    run_frame(1, 0, 1);
    a_last_cyc = out_cyc[1];
    checks++;
    if (n_out !== 2 || out_data[1][47:32] !== 16'h0010) begin
      errors++;
      $display("FAIL b2b_len_a: got %h required 0010", out_data[1][47:32]);
    end
    run_frame(1, 0, 0);
    checks++;
    if (n_out !== 2 || out_data[1] !== 64'h00AB00200A0B0C0D) begin
      errors++;
      $display("FAIL b2b_len_b: got %h required 00ab00200a0b0c0d", out_data[1]);
    end
    checks++;
    if (out_cyc[0] - a_last_cyc !== 2) begin
      errors++;
      $display("FAIL b2b_gap: got %0d cycles between last and first required 2",
               out_cyc[0] - a_last_cyc);
    end
    tx_size = 16'h0010;
  endtask

  task automatic test_reset_mid_frame();
    tx_frame_tready = 1;
    tx_orin_tvalid = 1; tx_orin_tdata = 64'h8877665544332211;
    tx_orin_tkeep = 8'hFF; tx_orin_tlast = 0; tx_orin_tuser = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (tx_frame_tvalid !== 1'b1 || tx_frame_tlast !== 1'b0 ||
        tx_frame_tdata !== 64'h2211887766554433) begin
      errors++;
      $display("FAIL rst_mid_data: got v=%b l=%b d=%h required 1/0/2211887766554433",
               tx_frame_tvalid, tx_frame_tlast, tx_frame_tdata);
    end
    rstn = 0;
    @(posedge clk); #1;
    rstn = 1;
    tx_orin_tvalid = 0;
    @(negedge clk);
    checks++;
    if (tx_frame_tvalid !== 1'b0 || tx_frame_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_idle: got v=%b cnt=%0d required 0/0", tx_frame_tvalid, tx_frame_cnt);
    end
    @(posedge clk); #1;
    load_two_beat();
    run_frame(2, 0, 0);
    checks++;
    if (n_out !== 4 || out_data[0] !== 64'h0E0F112233445566 ||
        out_data[1] !== 64'h221100100A0B0C0D) begin
      errors++;
      $display("FAIL rst_mid_hdr: got %h %h required 0e0f112233445566 221100100a0b0c0d",
               out_data[0], out_data[1]);
    end
    checks++;
    if (tx_frame_cnt !== 32'd1) begin
      errors++;
      $display("FAIL rst_mid_cnt: got %0d required 1", tx_frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_frame();
    test_backpressure();
    test_error();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
